io_hub: RTL and testbench

//   Memory-mapped IO register block for the pipelined SoC. It replaces the ad-hoc IO decode at the top level.

---
 rtl/io_pkg.sv | 28 ++
 rtl/io_fifo.sv | 53 +++++
 rtl/io_hub.sv | 143 ++++++++++++++
 tb/tb_io_hub.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the IO register block: register select bits,
// UART control/status bit positions and the drain FSM encoding.
package io_pkg;

  localparam int IO_LEDS_bit      = 0;
  localparam int IO_UART_DAT_bit  = 1;
  localparam int IO_UART_CTRL_bit = 2;
  localparam int IO_SSEG_bit      = 3;
  localparam int IO_TIMER_bit     = 4;

  localparam int CTRL_FLUSH_bit   = 0;
  localparam int CTRL_CLROVF_bit  = 1;
  localparam int STAT_FULL_bit    = 8;
  localparam int STAT_BUSY_bit    = 9;
  localparam int STAT_OVF_bit     = 10;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_ARM  = 2'd1,
    DRAIN_WAIT = 2'd2
  } drainState_t;

  // Isolate the lowest set bit so overlapping selects resolve to one register.
  function automatic logic [4:0] lowestBit(input logic [4:0] v);
    return v & (~v + 5'd1);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with combinational head output and flush.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr, wrPtr;
  logic             doPush, doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_hub.sv
// Memory-mapped IO block: LED/SSEG registers, buffered UART TX with drain FSM,
// free-running cycle timer and registered read-back.
module io_hub
  import io_pkg::*;
#(
  parameter int LED_W      = 16,
  parameter int SSEG_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMER_EN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_sel,
  input  logic [4:0]        word_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wmask,
  input  logic              mem_rstrb,
  output logic [31:0]       mem_rdata,
  output logic [LED_W-1:0]  leds,
  output logic [SSEG_W-1:0] sseg,
  output logic              uart_wr,
  output logic [7:0]        uart_data,
  input  logic              uart_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [4:0]  sel;
  logic        wrEn, rdEn;
  logic        push, flush, clrOvf, pop;
  logic        ovf, txBusy;
  logic        fifoFull, fifoEmpty;
  logic [7:0]  fifoHead;
  logic [CW-1:0] fifoCount;
  logic [31:0] timer, status, rdMux;
  drainState_t state, stateNext;

  assign sel    = lowestBit(word_addr);
  assign wrEn   = io_sel & (|mem_wmask);
  assign rdEn   = io_sel & mem_rstrb;
  assign push   = wrEn & sel[IO_UART_DAT_bit] & mem_wmask[0];
  assign flush  = wrEn & sel[IO_UART_CTRL_bit] & mem_wdata[CTRL_FLUSH_bit];
  assign clrOvf = wrEn & sel[IO_UART_CTRL_bit] & mem_wdata[CTRL_CLROVF_bit];

  // Byte-masked registers; bits above the width simply have no storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= '0;
      sseg <= '0;
    end else if (wrEn) begin
      for (int i = 0; i < LED_W; i++)
        if (sel[IO_LEDS_bit] && mem_wmask[i/8]) leds[i] <= mem_wdata[i];
      for (int i = 0; i < SSEG_W; i++)
        if (sel[IO_SSEG_bit] && mem_wmask[i/8]) sseg[i] <= mem_wdata[i];
    end
  end

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (mem_wdata[7:0]),
    .dout  (fifoHead),
    .count (fifoCount),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ovf <= 1'b0;
    else if (clrOvf)            ovf <= 1'b0;
    else if (push && fifoFull)  ovf <= 1'b1;
  end

  generate
    if (TIMER_EN != 0) begin : gTimer
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                          timer <= '0;
        else if (wrEn && sel[IO_TIMER_bit]) timer <= mem_wdata;
        else                                timer <= timer + 32'd1;
      end
    end else begin : gNoTimer
      assign timer = '0;
    end
  endgenerate

  // Drain FSM: one pop per transfer, then a fixed arm cycle before polling busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DRAIN_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    case (state)
      DRAIN_IDLE: if (!fifoEmpty && !uart_busy) begin
        pop       = 1'b1;
        stateNext = DRAIN_ARM;
      end
      DRAIN_ARM:  stateNext = DRAIN_WAIT;
      DRAIN_WAIT: if (!uart_busy) stateNext = DRAIN_IDLE;
      default:    stateNext = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_wr   <= 1'b0;
      uart_data <= '0;
    end else begin
      uart_wr <= pop;
      if (pop) uart_data <= fifoHead;
    end
  end

  assign txBusy = (fifoCount != '0) | (state != DRAIN_IDLE) | uart_busy;

  always_comb begin
    status                = '0;
    status[7:0]           = 8'(fifoCount);
    status[STAT_FULL_bit] = fifoFull;
    status[STAT_BUSY_bit] = txBusy;
    status[STAT_OVF_bit]  = ovf;
  end

  always_comb begin
    rdMux = '0;
    if      (sel[IO_LEDS_bit])      rdMux = 32'(leds);
    else if (sel[IO_UART_DAT_bit])  rdMux = '0;
    else if (sel[IO_UART_CTRL_bit]) rdMux = status;
    else if (sel[IO_SSEG_bit])      rdMux = 32'(sseg);
    else if (sel[IO_TIMER_bit])     rdMux = timer;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     mem_rdata <= '0;
    else if (rdEn) mem_rdata <= rdMux;
  end

endmodule

// File: tb/tb_io_hub.sv
// Directed self-checking bench for io_hub with a simple txuart busy model.
module tb_io_hub;

  logic        clk, reset, io_sel, mem_rstrb, uart_wr, uart_busy;
  logic [4:0]  word_addr;
  logic [31:0] mem_wdata, mem_rdata, rd;
  logic [3:0]  mem_wmask;
  logic [15:0] leds;
  logic [31:0] sseg;
  logic [7:0]  uart_data;

  int nChecks = 0, nFail = 0;
  int cyc = 0, busyCnt = 0;
  logic stuckBusy = 1'b0;
  logic [7:0] wrData[$];
  int         wrCyc[$];
  int         nBefore;

  localparam logic [4:0] A_LEDS = 5'b00001, A_DAT = 5'b00010, A_CTRL = 5'b00100,
                         A_SSEG = 5'b01000, A_TMR = 5'b10000;

  io_hub #(.LED_W(16), .SSEG_W(32), .FIFO_DEPTH(16), .TIMER_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_sel    (io_sel),
    .word_addr (word_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .leds      (leds),
    .sseg      (sseg),
    .uart_wr   (uart_wr),
    .uart_data (uart_data),
    .uart_busy (uart_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // txuart model: busy for 10 cycles after each write pulse; also logs pulses.
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) busyCnt = 0;
      if (uart_wr) begin
        wrData.push_back(uart_data);
        wrCyc.push_back(cyc);
        busyCnt = 10;
      end
      if (stuckBusy) uart_busy = 1'b1;
      else if (busyCnt > 0) begin
        uart_busy = 1'b1;
        busyCnt--;
      end else uart_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic busAcc(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic rs, output logic [31:0] r);
    io_sel = 1'b1; word_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = rs;
    @(negedge clk);
    io_sel = 1'b0; word_addr = '0; mem_wmask = '0; mem_rstrb = 1'b0;
    r = mem_rdata;
  endtask

  initial begin
    reset = 1'b1; io_sel = 0; word_addr = 0; mem_wdata = 0; mem_wmask = 0; mem_rstrb = 0;
    repeat (3) @(negedge clk);
    check("rst_leds", 32'(leds), 0);
    check("rst_sseg", sseg, 0);
    check("rst_uart_wr", 32'(uart_wr), 0);
    check("rst_rdata", mem_rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // LEDS byte mask
    busAcc(A_LEDS, 32'h0, 4'hF, 1'b0, rd);
    busAcc(A_LEDS, 32'hABCD_1234, 4'b0010, 1'b0, rd);
    check("leds_bytemask", 32'(leds), 32'h1200);
    busAcc(A_LEDS, 32'h0, 4'h0, 1'b1, rd);
    check("leds_read", rd, 32'h0000_1200);

    // SSEG, read-during-write returns old value, multi-bit select
    busAcc(A_SSEG, 32'h1234_5678, 4'hF, 1'b0, rd);
    busAcc(A_SSEG, 32'hDEAD_BEEF, 4'hF, 1'b1, rd);
    check("sseg_rd_old", rd, 32'h1234_5678);
    check("sseg_new", sseg, 32'hDEAD_BEEF);
    busAcc(5'b11000, 32'h0, 4'h0, 1'b1, rd);
    check("multisel_rd", rd, 32'hDEAD_BEEF);

    // UART drain of three back-to-back bytes
    wrData.delete(); wrCyc.delete();
    busAcc(A_DAT, 32'h41, 4'h1, 1'b0, rd);
    busAcc(A_DAT, 32'h42, 4'h1, 1'b0, rd);
    busAcc(A_DAT, 32'h43, 4'h1, 1'b0, rd);
    busAcc(A_CTRL, 32'h0, 4'h0, 1'b1, rd);
    check("txbusy_active", 32'(rd[9]), 1);
    for (int i = 0; i < 300 && wrData.size() < 3; i++) @(negedge clk);
    check("uart_npulses", wrData.size(), 3);
    repeat (20) @(negedge clk);
    check("uart_npulses_end", wrData.size(), 3);
    check("uart_b0", 32'(wrData[0]), 32'h41);
    check("uart_b1", 32'(wrData[1]), 32'h42);
    check("uart_b2", 32'(wrData[2]), 32'h43);
    check("uart_gap01", 32'(wrCyc[1] - wrCyc[0] >= 12), 1);
    check("uart_gap12", 32'(wrCyc[2] - wrCyc[1] >= 12), 1);
    busAcc(A_CTRL, 32'h0, 4'h0, 1'b1, rd);
    check("ctrl_idle", rd, 32'h0);

    // Overflow with busy stuck
    stuckBusy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) busAcc(A_DAT, 32'(i), 4'h1, 1'b0, rd);
    busAcc(A_CTRL, 32'h0, 4'h0, 1'b1, rd);
    check("ctrl_full_ovf", rd, 32'h710);
    busAcc(A_CTRL, 32'h2, 4'h1, 1'b0, rd);
    busAcc(A_CTRL, 32'h0, 4'h0, 1'b1, rd);
    check("ctrl_clrovf", rd, 32'h310);
    busAcc(A_CTRL, 32'h1, 4'h1, 1'b0, rd);
    busAcc(A_CTRL, 32'h0, 4'h0, 1'b1, rd);
    check("ctrl_flush", rd, 32'h200);

    // Timer wrap
    busAcc(A_TMR, 32'hFFFF_FFFE, 4'h1, 1'b0, rd);
    repeat (3) @(negedge clk);
    busAcc(A_TMR, 32'h0, 4'h0, 1'b1, rd);
    check("timer_wrap", rd, 32'h0000_0001);

    // Overlapping select resolves to UART_DAT; empty select reads 0
    busAcc(5'b00110, 32'h55, 4'h1, 1'b0, rd);
    busAcc(A_CTRL, 32'h0, 4'h0, 1'b1, rd);
    check("multisel_push", rd, 32'h201);
    busAcc(5'b00000, 32'h0, 4'h0, 1'b1, rd);
    check("nosel_read", rd, 32'h0);
    busAcc(A_CTRL, 32'h1, 4'h1, 1'b0, rd);

    // Reset mid-transfer
    stuckBusy = 1'b0;
    @(negedge clk);
    busAcc(A_LEDS, 32'h0, 4'h0, 1'b1, rd);
    busAcc(A_DAT, 32'h61, 4'h1, 1'b0, rd);
    busAcc(A_DAT, 32'h62, 4'h1, 1'b0, rd);
    busAcc(A_DAT, 32'h63, 4'h1, 1'b0, rd);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_leds", 32'(leds), 0);
    check("midrst_sseg", sseg, 0);
    check("midrst_rdata", mem_rdata, 0);
    check("midrst_uart_wr", 32'(uart_wr), 0);
    check("midrst_uart_data", 32'(uart_data), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    nBefore = wrData.size();
    repeat (30) @(negedge clk);
    check("midrst_no_tx", wrData.size(), nBefore);
    busAcc(A_CTRL, 32'h0, 4'h0, 1'b1, rd);
    check("midrst_ctrl", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
